// File: rtl/axi4_slave_mem.sv
// ---------------------------------------------------------------------------
// axi4_slave_mem
//   AXI4 responder with an internal word-addressed memory. Independent write
//   and read state machines each handle one outstanding burst. Supports
//   FIXED / INCR / WRAP bursts, byte strobes and clamped transfer sizes.
//   All outputs are registered.
//
//   Optional feature (compile-time macro):
//     AXI_SLV_RANGE_CHECK_EN - beats whose word address is at or beyond
//       MEM_WORDS, and bursts with BURST=11, are flagged as SLVERR. Errored
//       write beats are dropped; errored read beats return zero data.
//     Without it, addresses wrap modulo MEM_WORDS and every response is OKAY.
// ---------------------------------------------------------------------------
module axi4_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,  // 32 or 64
  parameter int MEM_WORDS  = 1024 // power of 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // write address channel
  input  logic [8:0]              AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [3:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  // write data channel
  input  logic [8:0]              WID,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  // write response channel
  output logic [8:0]              BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  // read address channel
  input  logic [8:0]              ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [3:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  // read data channel
  output logic [8:0]              RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int         STRB_W   = DATA_WIDTH / 8;
  localparam int         IDX_W    = $clog2(MEM_WORDS);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------

  // Address of the following beat. Oversized SIZE is clamped to the bus
  // width; WRAP with an illegal LEN and the reserved encoding behave as INCR.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [3:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [2:0]            eff_size;
    logic [2:0]            len_log2;
    logic                  wrap_ok;
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    eff_size = (size > MAX_SIZE) ? MAX_SIZE : size;
    inc      = ADDR_WIDTH'(1) << eff_size;
    wrap_ok  = 1'b1;
    len_log2 = 3'd0;
    case (len)
      4'd1:    len_log2 = 3'd1;
      4'd3:    len_log2 = 3'd2;
      4'd7:    len_log2 = 3'd3;
      4'd15:   len_log2 = 3'd4;
      default: wrap_ok  = 1'b0;
    endcase
    // Wrap boundary size is (LEN+1)*inc, always a power of two here.
    mask = (inc << len_log2) - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~mask) | ((addr + inc) & mask))
                                       : (addr + inc);
      default:     next_addr = addr + inc;
    endcase
  endfunction

  // Memory word index; upper address bits fold away (modulo MEM_WORDS).
  function automatic logic [IDX_W-1:0] mem_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] word;
    word    = addr >> MAX_SIZE;
    mem_idx = word[IDX_W-1:0];
  endfunction

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // -------------------------------------------------------------------------
  // Write path state
  // -------------------------------------------------------------------------
  w_state_t              w_state, w_next;
  logic [8:0]            w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [3:0]            w_len;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [3:0]            w_cnt;
  logic                  w_err;

  logic aw_hs, w_hs, b_hs, w_done;
  logic w_beat_err;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  assign aw_hs      = AWVALID && AWREADY;
  assign w_hs       = WVALID  && WREADY;
  assign b_hs       = BVALID  && BREADY;
  // The burst ends on WLAST or when the beat count reaches LEN, whichever is first.
  assign w_done     = w_hs && (WLAST || (w_cnt == w_len));
  assign w_addr_nxt = next_addr(w_addr, w_len, w_size, w_burst);

  // -------------------------------------------------------------------------
  // Read path state
  // -------------------------------------------------------------------------
  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [3:0]            r_cnt;

  logic ar_hs, r_hs, r_last_beat;
  logic ar_err, rn_err;
  logic [ADDR_WIDTH-1:0] r_addr_nxt;

  assign ar_hs       = ARVALID && ARREADY;
  assign r_hs        = RVALID  && RREADY;
  assign r_last_beat = (r_cnt == r_len);
  assign r_addr_nxt  = next_addr(r_addr, r_len, r_size, r_burst);

  // -------------------------------------------------------------------------
  // Beat error detection
  // -------------------------------------------------------------------------
`ifdef AXI_SLV_RANGE_CHECK_EN
  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] word;
    word         = addr >> MAX_SIZE;
    out_of_range = (word >> IDX_W) != '0;
  endfunction

  assign w_beat_err = out_of_range(w_addr)     || (w_burst == 2'b11);
  assign ar_err     = out_of_range(ARADDR)     || (ARBURST == 2'b11);
  assign rn_err     = out_of_range(r_addr_nxt) || (r_burst == 2'b11);
`else
  assign w_beat_err = 1'b0;
  assign ar_err     = 1'b0;
  assign rn_err     = 1'b0;
`endif

  // WID carries no meaning for a single-burst responder.
  logic unused_wid;
  assign unused_wid = ^WID;

  // -------------------------------------------------------------------------
  // Write FSM
  // -------------------------------------------------------------------------

  // Write state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // Write next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)  w_next = W_DATA;
      W_DATA:  if (w_done) w_next = W_RESP;
      W_RESP:  if (b_hs)   w_next = W_IDLE;
      default:             w_next = W_IDLE;
    endcase
  end

  // Write channel registers: ready/valid follow the next state so they are
  // registered, burst fields are captured on AW, response fields on last W.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= RESP_OKAY;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      AWREADY <= (w_next == W_IDLE);
      WREADY  <= (w_next == W_DATA);
      BVALID  <= (w_next == W_RESP);
      if (aw_hs) begin
        w_id    <= AWID;
        w_addr  <= AWADDR;
        w_len   <= AWLEN;
        w_size  <= AWSIZE;
        w_burst <= AWBURST;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end else if (w_hs) begin
        w_addr <= w_addr_nxt;
        w_cnt  <= w_cnt + 4'd1;
        w_err  <= w_err || w_beat_err;
        if (w_done) begin
          BID   <= w_id;
          BRESP <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Memory write with per-byte strobes; errored beats are dropped.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; contents are undefined until
    // written, which keeps it mappable onto RAM.
    if (w_hs && !w_beat_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[mem_idx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read FSM
  // -------------------------------------------------------------------------

  // Read state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // Read next-state logic.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)                r_next = R_DATA;
      R_DATA:  if (r_hs && r_last_beat)  r_next = R_IDLE;
      default:                           r_next = R_IDLE;
    endcase
  end

  // Read channel registers: beat 0 is fetched on AR, each accepted beat loads
  // the following one; everything holds while RVALID && !RREADY. A write to
  // the same word on the same edge is not visible (old data is returned).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else begin
      ARREADY <= (r_next == R_IDLE);
      RVALID  <= (r_next == R_DATA);
      if (ar_hs) begin
        r_addr  <= ARADDR;
        r_len   <= ARLEN;
        r_size  <= ARSIZE;
        r_burst <= ARBURST;
        r_cnt   <= '0;
        RID     <= ARID;
        RDATA   <= ar_err ? '0 : mem[mem_idx(ARADDR)];
        RRESP   <= ar_err ? RESP_SLVERR : RESP_OKAY;
        RLAST   <= (ARLEN == 4'd0);
      end else if (r_hs) begin
        if (r_last_beat) begin
          RLAST <= 1'b0;
        end else begin
          r_addr <= r_addr_nxt;
          r_cnt  <= r_cnt + 4'd1;
          RDATA  <= rn_err ? '0 : mem[mem_idx(r_addr_nxt)];
          RRESP  <= rn_err ? RESP_SLVERR : RESP_OKAY;
          RLAST  <= ((r_cnt + 4'd1) == r_len);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_axi4_slave_mem
//   Directed self-checking bench for axi4_slave_mem. Inputs are driven and
//   outputs sampled on the falling edge; the DUT acts on the rising edge.
//   Define AXI_SLV_RANGE_CHECK_EN for both files to exercise error responses.
// ---------------------------------------------------------------------------
module tb_axi4_slave_mem;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 1024;
  localparam int TMO = 50;

  logic          clk;
  logic          rst_n;
  logic [8:0]    AWID;
  logic [AW-1:0] AWADDR;
  logic [3:0]    AWLEN;
  logic [2:0]    AWSIZE;
  logic [1:0]    AWBURST;
  logic          AWVALID;
  logic          AWREADY;
  logic [8:0]    WID;
  logic [DW-1:0] WDATA;
  logic [3:0]    WSTRB;
  logic          WLAST;
  logic          WVALID;
  logic          WREADY;
  logic [8:0]    BID;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic [8:0]    ARID;
  logic [AW-1:0] ARADDR;
  logic [3:0]    ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic          ARVALID;
  logic          ARREADY;
  logic [8:0]    RID;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY;

  axi4_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Write beat stimulus and captured read/response results.
  logic [DW-1:0] wd [16];
  logic [3:0]    ws [16];
  logic [DW-1:0] rd [16];
  logic [1:0]    rr [16];
  logic          rl [16];
  logic [8:0]    rid_s;
  logic [8:0]    bid_s;
  logic [1:0]    bresp_s;

  bit bp_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Full write transaction; BREADY is held low for bdelay cycles of BVALID.
  task automatic axi_write(input logic [8:0] id, input logic [AW-1:0] addr,
                           input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int nbeats,
                           input bit use_wlast, input int bdelay);
    int n;
    @(negedge clk);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
    AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < TMO) begin @(negedge clk); n++; end
    if (n == TMO) check("aw_timeout", 1, 0);
    @(negedge clk);
    AWVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      WDATA = wd[i]; WSTRB = ws[i]; WLAST = use_wlast && (i == nbeats - 1);
      WVALID = 1'b1;
      n = 0;
      while (!WREADY && n < TMO) begin @(negedge clk); n++; end
      if (n == TMO) check("w_timeout", 1, 0);
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    check("bvalid_latency", BVALID, 1);
    for (int c = 0; c < bdelay; c++) begin
      check("b_stall_valid", BVALID, 1);
      check("b_stall_id", BID, id);
      @(negedge clk);
    end
    n = 0;
    while (!BVALID && n < TMO) begin @(negedge clk); n++; end
    if (n == TMO) check("b_timeout", 1, 0);
    bid_s = BID; bresp_s = BRESP;
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    check("b_drop", BVALID, 0);
    check("awready_after_b", AWREADY, 1);
  endtask

  // Full read transaction with RREADY held high; results land in rd/rr/rl.
  task automatic axi_read(input logic [8:0] id, input logic [AW-1:0] addr,
                          input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
    int n;
    @(negedge clk);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < TMO) begin @(negedge clk); n++; end
    if (n == TMO) check("ar_timeout", 1, 0);
    @(negedge clk);
    ARVALID = 1'b0;
    RREADY  = 1'b1;
    check("rvalid_latency", RVALID, 1);
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!RVALID && n < TMO) begin @(negedge clk); n++; end
      if (n == TMO) check("r_timeout", 1, 0);
      rd[i] = RDATA; rr[i] = RRESP; rl[i] = RLAST; rid_s = RID;
      @(negedge clk);
    end
    RREADY = 1'b0;
    check("r_drop", RVALID, 0);
    check("arready_after_r", ARREADY, 1);
  endtask

  initial begin
    int n;
    logic [DW-1:0] exp_wrap [4];

    rst_n = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_awready", AWREADY, 0);
    check("rst_wready",  WREADY,  0);
    check("rst_bvalid",  BVALID,  0);
    check("rst_arready", ARREADY, 0);
    check("rst_rvalid",  RVALID,  0);
    check("rst_rlast",   RLAST,   0);
    check("rst_bid_bresp", {BID, BRESP}, 0);
    check("rst_rid_rdata_rresp", {RID, RDATA, RRESP}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_awready", AWREADY, 1);
    check("post_rst_arready", ARREADY, 1);

    // Single write then read.
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(9'h055, 32'h10, 4'd0, 3'd2, 2'b01, 1, 1'b1, 0);
    check("single_bresp", bresp_s, 2'b00);
    check("single_bid", bid_s, 9'h055);
    axi_read(9'h1A3, 32'h10, 4'd0, 3'd2, 2'b01);
    check("single_rdata", rd[0], 32'hDEADBEEF);
    check("single_rlast", rl[0], 1);
    check("single_rresp", rr[0], 2'b00);
    check("single_rid", rid_s, 9'h1A3);

    // INCR burst of 1..4.
    for (int i = 0; i < 4; i++) begin wd[i] = DW'(i + 1); ws[i] = 4'hF; end
    axi_write(9'h002, 32'h100, 4'd3, 3'd2, 2'b01, 4, 1'b1, 0);
    check("incr_bresp", bresp_s, 2'b00);
    axi_read(9'h003, 32'h100, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("incr_rdata%0d", i), rd[i], DW'(i + 1));
      check($sformatf("incr_rlast%0d", i), rl[i], (i == 3));
    end

    // WRAP read starting mid-block: words C,D then wrap to A,B.
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    axi_write(9'h004, 32'h0, 4'd3, 3'd2, 2'b01, 4, 1'b1, 0);
    axi_read(9'h005, 32'h08, 4'd3, 3'd2, 2'b10);
    exp_wrap = '{32'hC, 32'hD, 32'hA, 32'hB};
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap_rdata%0d", i), rd[i], exp_wrap[i]);

    // Read backpressure: RREADY 1,0,0,1,1,1 over a 4-beat read of 1..4.
    @(negedge clk);
    ARID = 9'h0F0; ARADDR = 32'h100; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01;
    ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < TMO) begin @(negedge clk); n++; end
    if (n == TMO) check("bp_ar_timeout", 1, 0);
    @(negedge clk);
    ARVALID = 1'b0;
    begin
      int beat;
      beat = 0;
      for (int c = 0; c < 6; c++) begin
        RREADY = bp_pat[c];
        check($sformatf("bp_rvalid_c%0d", c), RVALID, 1);
        check($sformatf("bp_rdata_c%0d", c), RDATA, DW'(beat + 1));
        check($sformatf("bp_rlast_c%0d", c), RLAST, (beat == 3));
        check($sformatf("bp_rid_c%0d", c), RID, 9'h0F0);
        @(negedge clk);
        if (bp_pat[c]) beat++;
      end
    end
    RREADY = 1'b0;
    check("bp_arready_after", ARREADY, 1);

    // Write response backpressure: BREADY low for 5 cycles.
    wd[0] = 32'h5A5A5A5A; ws[0] = 4'hF;
    axi_write(9'h1FF, 32'h200, 4'd0, 3'd2, 2'b01, 1, 1'b1, 5);
    check("bstall_bid", bid_s, 9'h1FF);
    check("bstall_bresp", bresp_s, 2'b00);

    // Strobes with FIXED burst onto a word of all ones.
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    axi_write(9'h006, 32'h300, 4'd0, 3'd2, 2'b01, 1, 1'b1, 0);
    wd[0] = 32'h11223344; ws[0] = 4'b0001;
    wd[1] = 32'h11223344; ws[1] = 4'b0100;
    axi_write(9'h007, 32'h300, 4'd1, 3'd2, 2'b00, 2, 1'b1, 0);
    axi_read(9'h008, 32'h300, 4'd0, 3'd2, 2'b01);
    check("strb_fixed_rdata", rd[0], 32'hFF22FF44);

    // Early WLAST ends a LEN=3 burst after two beats.
    wd[0] = 32'h7; wd[1] = 32'h8; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_write(9'h009, 32'h400, 4'd3, 3'd2, 2'b01, 2, 1'b1, 0);
    check("early_wlast_bresp", bresp_s, 2'b00);
    axi_read(9'h00A, 32'h400, 4'd1, 3'd2, 2'b01);
    check("early_wlast_rd0", rd[0], 32'h7);
    check("early_wlast_rd1", rd[1], 32'h8);

    // Beat count reaching LEN ends the burst without WLAST.
    wd[0] = 32'h55; wd[1] = 32'h66;
    axi_write(9'h00B, 32'h500, 4'd1, 3'd2, 2'b01, 2, 1'b0, 0);
    axi_read(9'h00C, 32'h500, 4'd1, 3'd2, 2'b01);
    check("len_end_rd0", rd[0], 32'h55);
    check("len_end_rd1", rd[1], 32'h66);

    // Oversized SIZE clamps to 4-byte steps: 0x100, 0x104 -> 1, 2.
    axi_read(9'h00D, 32'h100, 4'd1, 3'd3, 2'b01);
    check("size_clamp_rd0", rd[0], 32'h1);
    check("size_clamp_rd1", rd[1], 32'h2);

    // Reset asserted in the middle of a read burst.
    @(negedge clk);
    ARID = 9'h00E; ARADDR = 32'h100; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01;
    ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < TMO) begin @(negedge clk); n++; end
    if (n == TMO) check("rst_ar_timeout", 1, 0);
    @(negedge clk);
    ARVALID = 1'b0;
    check("midrst_rvalid_before", RVALID, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rvalid_async", RVALID, 0);
    check("midrst_arready_async", ARREADY, 0);
    check("midrst_rlast_async", RLAST, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_arready_release", ARREADY, 0);
    @(negedge clk);
    check("midrst_arready_after", ARREADY, 1);
    check("midrst_awready_after", AWREADY, 1);
    check("midrst_rvalid_after", RVALID, 0);
    axi_read(9'h00F, 32'h100, 4'd1, 3'd2, 2'b01);
    check("midrst_mem_rd0", rd[0], 32'h1);
    check("midrst_mem_rd1", rd[1], 32'h2);

`ifdef AXI_SLV_RANGE_CHECK_EN
    // Out-of-range word MEM_WORDS: dropped write, SLVERR, zero read data.
    wd[0] = 32'h12345678; ws[0] = 4'hF;
    axi_write(9'h010, AW'(MW * 4), 4'd0, 3'd2, 2'b01, 1, 1'b1, 0);
    check("range_bresp", bresp_s, 2'b10);
    axi_read(9'h011, 32'h0, 4'd0, 3'd2, 2'b01);
    check("range_word0_intact", rd[0], 32'hA);
    axi_read(9'h012, AW'(MW * 4), 4'd0, 3'd2, 2'b01);
    check("range_rresp", rr[0], 2'b10);
    check("range_rdata", rd[0], 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/axi4_slave_mem.md
# axi4_slave_mem

AXI4 responder (slave) with an internal word-addressed memory. It terminates one master on the team's AXI4 interface: it accepts write and read bursts, stores data with byte strobes, and returns write responses and read data. It is the RTL DUT end of the master driver/monitor environment. Its outputs meet the interface's valid-stability assertions.

## Interface
- ADDR_WIDTH, 32: byte address width; the package default applies.
- DATA_WIDTH, 32: data bus width; must be 32 or 64.
- MEM_WORDS, 1024: memory depth in DATA_WIDTH words; must be a power of 2.
- clk  in  1  clock; all logic samples on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low. Deassertion is synchronous to clk externally.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  9/ADDR_WIDTH/4/3/2/1  write address channel.
- AWREADY  out  1  write address ready.
- WID/WDATA/WSTRB/WLAST/WVALID  in  9/DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel. WID is ignored.
- WREADY  out  1  write data ready.
- BID/BRESP/BVALID  out  9/2/1  write response.
- BREADY  in  1  response ready.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  9/ADDR_WIDTH/4/3/2/1  read address channel.
- ARREADY  out  1  read address ready.
- RID/RDATA/RRESP/RLAST/RVALID  out  9/DATA_WIDTH/2/1/1  read data channel.
- RREADY  in  1  read data ready.

## Operation
- Write and read paths are independent FSMs. Each path handles one outstanding burst; there is no interleaving.
- Write FSM states are W_IDLE, W_DATA and W_RESP.
  - W_IDLE: AWREADY=1. On AWVALID&&AWREADY, latch ID, address, LEN, SIZE and BURST; clear the beat counter and error flag; go to W_DATA.
  - W_DATA: WREADY=1. On each W handshake, write each byte lane whose WSTRB bit is set, then advance the address.
    - On a handshake with WLAST=1, or when the beat counter equals LEN, go to W_RESP. Whichever occurs first ends the burst.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=OKAY(00) or SLVERR(10). On BREADY, go to W_IDLE.
- Read FSM states are R_IDLE and R_DATA.
  - R_IDLE: ARREADY=1. On AR handshake, latch the fields, register beat 0 into RDATA and go to R_DATA.
  - R_DATA: RVALID=1; RLAST=1 when beat count equals LEN. On RVALID&&RREADY, either load the next beat or, if this was the last beat, go to R_IDLE.
- Address update: inc = 1<<SIZE. Supported SIZE values are 0 to log2(DATA_WIDTH/8). A larger SIZE is clamped to the bus width.
  - FIXED (00): the address is unchanged between beats.
  - INCR (01): addr+inc, computed modulo 2^ADDR_WIDTH.
  - WRAP (10): the wrap size is W=(LEN+1)*inc. Next address = (addr & ~(W-1)) | ((addr+inc) & (W-1)). LEN must be 1, 3, 7 or 15; any other LEN is treated as INCR.
  - Reserved (11): treated as INCR.
- Word index = (addr >> log2(DATA_WIDTH/8)) mod MEM_WORDS. Reads always return the full word; byte-lane selection is the master's job.
- A read and a write to the same word on the same edge: the read returns the old data.
- Memory contents are not reset.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, ARREADY=0, RVALID=0, RLAST=0, BID/BRESP/RID/RDATA/RRESP=0. In the first cycle after reset release, AWREADY=1 and ARREADY=1.
- All outputs are registered.
- Write path cycles:
  - AW handshake at edge N gives WREADY=1 in cycle N+1.
  - The last W handshake at edge M gives BVALID=1 in cycle M+1.
  - B handshake at edge K gives AWREADY=1 in cycle K+1.
- Read path cycles:
  - AR handshake at edge N gives RVALID=1 with beat 0 in cycle N+1.
  - Beats then stream one per cycle while RREADY=1.
  - After the last R handshake at edge K, ARREADY=1 in cycle K+1.
- While BVALID&&!BREADY or RVALID&&!RREADY, all response and data fields are held stable.
- Reset asserted mid-burst: both FSMs return to IDLE immediately; partially written data remains in memory.

## Configuration
- AXI_SLV_RANGE_CHECK_EN: compiled in, any beat whose word address is at or beyond MEM_WORDS, or any burst with BURST=11, is an error:
  - write: the beat is not performed and BRESP=SLVERR for the whole burst.
  - read: the beat returns RDATA=0 with RRESP=SLVERR; the other beats keep their own RRESP.
- Without the macro, addresses wrap modulo MEM_WORDS and every response is OKAY.

## Test plan
- Single write then read: AW addr 0x10, LEN=0, SIZE=2, INCR, WDATA=0xDEADBEEF, WSTRB=F, then AR 0x10 -> BRESP=00, BID=AWID; RDATA=0xDEADBEEF, RLAST=1 on beat 0.
- INCR burst: AW 0x100, LEN=3, data 1..4 -> read of 0x100 LEN=3 returns 1,2,3,4 with RLAST only on beat 3.
- WRAP burst: write 0x00..0x0C = A,B,C,D, then AR 0x08, LEN=3, SIZE=2, WRAP -> returns C,D,A,B.
- Backpressure: RREADY toggles 1,0,0,1 during a 4-beat read -> RDATA/RLAST/RID are stable in the stalled cycles; BREADY held low for 5 cycles keeps BVALID and BID constant.
- Strobes and FIXED: write 0xFFFFFFFF, then a FIXED LEN=1 burst to the same address with WSTRB=0001 then 0100, data 0x11223344 -> read returns 0xFF22FF44.
- With AXI_SLV_RANGE_CHECK_EN: write to word MEM_WORDS -> BRESP=10 and memory unchanged; read there -> RRESP=10, RDATA=0. Reset mid-read -> RVALID=0 asynchronously and ARREADY=1 one cycle after release.
